// File: rtl/shift_unit_pkg.sv
// ----------------------------------------------------------------------------
// shift_unit_pkg
//   Shared types and constants for the iterative right-shift unit.
//   - shift_state_e : FSM state encoding (IDLE / SHIFT / DONE)
//   - SHIFT_SRL / SHIFT_SRA : encodings of the arith_i opcode bit
// ----------------------------------------------------------------------------
package shift_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_e;

    localparam logic SHIFT_SRL = 1'b0;  // logical shift, zero fill
    localparam logic SHIFT_SRA = 1'b1;  // arithmetic shift, sign fill

endpackage : shift_unit_pkg

// File: rtl/shift_right_step.sv
// ----------------------------------------------------------------------------
// shift_right_step
//   Combinational right shift of a WIDTH-bit word by amt_i positions, with the
//   vacated upper bits taken from fill_i. The parent only ever requests
//   amounts in 0..STEP, but any amount below WIDTH is handled correctly.
// Ports:
//   data_i   in  WIDTH    word to shift
//   amt_i    in  SHAMT_W  shift distance
//   fill_i   in  1        value shifted in at the top
//   result_o out WIDTH    shifted word
// ----------------------------------------------------------------------------
module shift_right_step #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] amt_i,
    input  logic               fill_i,
    output logic [WIDTH-1:0]   result_o
);

    logic [WIDTH-1:0] res_s;
    logic [SHAMT_W:0] idx_s;

    // Per output bit: take the source bit amt positions higher, or the fill
    // bit once that source index runs off the top of the word.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        idx_s = {(SHAMT_W+1){1'b0}};
        for (int j = 0; j < WIDTH; j++) begin
            idx_s = (SHAMT_W+1)'(j) + {1'b0, amt_i};
            if (idx_s[SHAMT_W] == 1'b0) begin
                res_s[j] = data_i[idx_s[SHAMT_W-1:0]];
            end else begin
                res_s[j] = fill_i;
            end
        end
    end

    assign result_o = res_s;

endmodule : shift_right_step

// File: rtl/shift_right_unit.sv
// ----------------------------------------------------------------------------
// shift_right_unit
//   Multi-cycle iterative right shifter (SRL / SRA) for the EX stage. Moves
//   STEP bit positions per clock; busy_o lets the hazard unit stall while an
//   operation is in flight, done_o pulses for one cycle with the result.
// Ports:
//   clk       in  1        rising-edge clock
//   reset     in  1        synchronous, active-high
//   start_i   in  1        request, accepted in IDLE or DONE only
//   arith_i   in  1        1 = SRA, 0 = SRL (sampled at accept)
//   shamt_i   in  SHAMT_W  shift amount (sampled at accept)
//   data_i    in  WIDTH    operand (sampled at accept)
//   busy_o    out 1        high while shifting
//   done_o    out 1        one-cycle completion pulse
//   result_o  out WIDTH    working/result register
// ----------------------------------------------------------------------------
module shift_right_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               arith_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    // STEP may equal WIDTH, so it needs one bit more than a shift amount.
    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W+1)'(STEP);

    shift_state_e       state_r;
    shift_state_e       state_nxt_s;
    logic               busy_r;
    logic               done_r;
    logic               busy_nxt_s;
    logic               done_nxt_s;
    logic [WIDTH-1:0]   result_r;
    logic [SHAMT_W-1:0] rem_r;
    logic               fill_r;
    logic               accept_s;
    logic               last_s;
    logic [SHAMT_W-1:0] k_s;
    logic [WIDTH-1:0]   step_res_s;

    assign accept_s = start_i && ((state_r == S_IDLE) || (state_r == S_DONE));
    // Final SHIFT cycle when what is left fits in a single step.
    assign last_s   = ({1'b0, rem_r} <= STEP_W);

    // Distance moved this cycle: min(rem, STEP); never exceeds rem.
    always_comb begin
        k_s = rem_r;
        if (last_s) begin
            k_s = rem_r;
        end else begin
            k_s = STEP_W[SHAMT_W-1:0];
        end
    end

    shift_right_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .data_i   (result_r),
        .amt_i    (k_s),
        .fill_i   (fill_r),
        .result_o (step_res_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; start_i only matters in IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (shamt_i != {SHAMT_W{1'b0}}) begin
                        state_nxt_s = S_SHIFT;
                    end else begin
                        state_nxt_s = S_DONE;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_SHIFT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode from the next state, so the flags register in step
    // with the state they describe.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            S_SHIFT: busy_nxt_s = 1'b1;
            S_DONE:  done_nxt_s = 1'b1;
            S_IDLE:  begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Datapath: load operands on accept, shift while in SHIFT, hold otherwise.
    // The fill bit is frozen at accept so the sign is not re-derived from the
    // partially shifted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {WIDTH{1'b0}};
            rem_r    <= {SHAMT_W{1'b0}};
            fill_r   <= 1'b0;
        end else if (accept_s) begin
            result_r <= data_i;
            rem_r    <= shamt_i;
            fill_r   <= (arith_i == SHIFT_SRA) && data_i[WIDTH-1];
        end else if (state_r == S_SHIFT) begin
            result_r <= step_res_s;
            rem_r    <= rem_r - k_s;
            fill_r   <= fill_r;
        end else begin
            result_r <= result_r;
            rem_r    <= rem_r;
            fill_r   <= fill_r;
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;

endmodule : shift_right_unit

// File: tb/tb_shift_right_unit.sv
// ----------------------------------------------------------------------------
// tb_shift_right_unit
//   Directed bench for shift_right_unit: one STEP=1 instance and one STEP=4
//   instance sharing clock, reset and operand inputs, with separate starts.
// ----------------------------------------------------------------------------
module tb_shift_right_unit;

    logic        clk;
    logic        reset;
    logic        start1;
    logic        start4;
    logic        arith;
    logic [4:0]  shamt;
    logic [31:0] data;
    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;

    int n_cmp;
    int n_mis;

    shift_right_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start1),
        .arith_i  (arith),
        .shamt_i  (shamt),
        .data_i   (data),
        .busy_o   (busy1),
        .done_o   (done1),
        .result_o (res1)
    );

    shift_right_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start4),
        .arith_i  (arith),
        .shamt_i  (shamt),
        .data_i   (data),
        .busy_o   (busy4),
        .done_o   (done4),
        .result_o (res4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, scramble the operand inputs afterwards, track busy
    // each cycle and check the done cycle, result, and post-done hold.
    task automatic run_op(input string tag, input logic use4, input logic ar,
                          input logic [4:0] sh, input logic [31:0] d,
                          input logic [31:0] exp_res, input int exp_lat,
                          input logic poke);
        int lat;
        logic b;
        logic dn;
        logic [31:0] r;
        arith = ar;
        shamt = sh;
        data  = d;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start4 = 1'b0;
        arith  = ~ar;
        shamt  = 5'd7;
        data   = 32'hDEAD_BEEF;
        lat    = 0;
        for (int c = 1; c <= 40; c++) begin
            b  = use4 ? busy4 : busy1;
            dn = use4 ? done4 : done1;
            check($sformatf("%s busy c%0d", tag, c), {31'd0, b},
                  {31'd0, (c < exp_lat)});
            if (dn) begin
                lat = c;
                break;
            end
            if (poke && b) begin
                if (use4) start4 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0;
                start4 = 1'b0;
            end
            tick();
        end
        start1 = 1'b0;
        start4 = 1'b0;
        check($sformatf("%s latency", tag), lat, exp_lat);
        r = use4 ? res4 : res1;
        check($sformatf("%s result", tag), r, exp_res);
        tick();
        check($sformatf("%s done after", tag), {31'd0, (use4 ? done4 : done1)}, 32'd0);
        check($sformatf("%s hold", tag), (use4 ? res4 : res1), exp_res);
    endtask

    initial begin
        n_cmp  = 0;
        n_mis  = 0;
        reset  = 1'b1;
        start1 = 1'b1;
        start4 = 1'b1;
        arith  = 1'b1;
        shamt  = 5'd3;
        data   = 32'hA5A5_5A5A;

        // 1. reset with live-looking inputs
        tick();
        data = 32'h8765_4321;
        tick();
        check("rst busy1",   {31'd0, busy1}, 32'd0);
        check("rst done1",   {31'd0, done1}, 32'd0);
        check("rst result1", res1, 32'h0000_0000);
        check("rst busy4",   {31'd0, busy4}, 32'd0);
        check("rst result4", res4, 32'h0000_0000);
        reset  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        tick();

        // 2. SRL shamt 4
        run_op("srl4", 1'b0, 1'b0, 5'd4, 32'h8000_00F0, 32'h0800_000F, 5, 1'b0);
        // 3. SRA shamt 4, SRA shamt 31 with start pokes while busy
        run_op("sra4", 1'b0, 1'b1, 5'd4, 32'h8000_00F0, 32'hF800_000F, 5, 1'b0);
        run_op("sra31", 1'b0, 1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32, 1'b1);
        // SRA of a positive value fills with zeros
        run_op("sra_pos", 1'b0, 1'b1, 5'd8, 32'h7F00_0000, 32'h007F_0000, 9, 1'b0);
        // 4. shamt 0
        run_op("sh0", 1'b0, 1'b0, 5'd0, 32'h1234_5678, 32'h1234_5678, 1, 1'b0);
        // 5. STEP=4 instance
        run_op("s4_srl31", 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 9, 1'b0);
        run_op("s4_sra6", 1'b1, 1'b1, 5'd6, 32'h8000_0040, 32'hFE00_0001, 3, 1'b0);

        // 6a. reset in cycle 10 of a shamt-31 op
        arith  = 1'b0;
        shamt  = 5'd31;
        data   = 32'hFFFF_0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("abort busy c10", {31'd0, busy1}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", {31'd0, busy1}, 32'd0);
        check("abort done", {31'd0, done1}, 32'd0);
        check("abort result", res1, 32'h0000_0000);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (done1) seen++;
            end
            check("abort no done", seen, 0);
        end

        // 6b. start held high across DONE: back-to-back accept
        arith  = 1'b1;
        shamt  = 5'd2;
        data   = 32'hF000_0000;
        start1 = 1'b1;
        tick();
        arith = 1'b0;
        shamt = 5'd1;
        data  = 32'h0000_00FF;
        check("b2b c1 busy", {31'd0, busy1}, 32'd1);
        tick();
        check("b2b c2 busy", {31'd0, busy1}, 32'd1);
        tick();
        check("b2b c3 done", {31'd0, done1}, 32'd1);
        check("b2b c3 result", res1, 32'hFC00_0000);
        tick();
        start1 = 1'b0;
        check("b2b c4 busy", {31'd0, busy1}, 32'd1);
        check("b2b c4 done", {31'd0, done1}, 32'd0);
        check("b2b c4 loaded", res1, 32'h0000_00FF);
        tick();
        check("b2b c5 done", {31'd0, done1}, 32'd1);
        check("b2b c5 result", res1, 32'h0000_007F);
        tick();
        check("b2b c6 idle", {31'd0, (busy1 | done1)}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_shift_right_unit
